decoder_dispatch_scheduler: RTL and testbench
=============================================

Name: decoder_dispatch_scheduler

Overview:
- Sequences the address tracker FIFO and shares its head window between 8 decoders, organised as 4 decoder pairs.
- Takes the two head addresses (head+0, head+1) and issues them to an idle pair, chosen round-robin.
- Pulses the tracker's read (pop-two) line at the same time.
- Tracks per-decoder busy state from done pulses, so the tracker is only popped when a pair can accept work.

Parameters:
ADDR_W, 20, width of one decoder address
NUM_PAIRS, 4, number of decoder pairs (decoders = 2*NUM_PAIRS)
CNT_W, 10, width of tracker occupancy count (0..512)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sched_en  input  1  dispatch enable; low stops new grants
fifo_count  input  CNT_W  tracker occupancy (entries written, not yet popped)
fifo_wr  input  1  tracker write strobe in this cycle
win_addr0  input  ADDR_W  tracker head+0 address
win_addr1  input  ADDR_W  tracker head+1 address
dec_done  input  2*NUM_PAIRS  per-decoder completion pulse
fifo_pop  output  1  tracker read strobe (pops two entries)
dec_start  output  2*NUM_PAIRS  per-decoder start pulse
dec_addr_even  output  ADDR_W  address for even decoder of granted pair
dec_addr_odd  output  ADDR_W  address for odd decoder of granted pair
dec_busy  output  2*NUM_PAIRS  registered busy flags
sched_idle  output  1  FSM in IDLE and all busy flags clear
done_err  output  1  sticky: done received for a non-busy decoder

Behaviour:
- Reset values:
  - FSM=IDLE; rr_ptr=0; grant=0.
  - fifo_pop, dec_start, dec_busy, done_err = 0.
  - dec_addr_even/odd = 0.
  - sched_idle = 1.
  - Reset mid-operation drops all busy state. Any pulse in flight is cancelled asynchronously.
- All outputs are registered.
- A pair is idle when both of its busy bits are 0.
- IDLE:
  - Goes to ISSUE when sched_en=1, fifo_count>=2 and at least one pair is idle.
  - The grant is latched on this transition: the first idle pair searching from rr_ptr upward, wrapping mod NUM_PAIRS.
  - With fifo_count<2, the FSM stays in IDLE. A single queued entry is never dispatched.
- ISSUE:
  - If fifo_wr=0 in this cycle, the next edge produces a one-cycle pulse of:
    - fifo_pop=1;
    - dec_start[2*grant] and dec_start[2*grant+1] =1;
    - dec_addr_even=win_addr0 and dec_addr_odd=win_addr1, sampled this cycle and held until the next issue;
    - busy bits of the granted pair set to 1;
    - rr_ptr=grant+1 mod NUM_PAIRS.
  - The FSM then moves to SETTLE.
  - If fifo_wr=1, nothing is issued and the FSM stays in ISSUE. The tracker treats a simultaneous read and write as a no-op, so popping then would lose the pop.
  - sched_en dropping in ISSUE does not abort an issue already granted.
- SETTLE:
  - Lasts one cycle, with no outputs asserted, so the tracker head and fifo_count update.
  - Always returns to IDLE.
- Latency:
  - From eligibility seen in IDLE to the start/pop pulse: 2 cycles.
  - Minimum spacing between issues: 3 cycles.
- Busy tracking:
  - dec_done[i]=1 clears busy[i] on the next edge.
  - If busy[i]=0 when dec_done[i]=1, the done is ignored and done_err is set (cleared only by reset).
  - Set and clear cannot coincide on the same bit, because starts target only idle pairs.
  - A pair becomes idle again only once both of its decoders are done.
- fifo_count is trusted as given. No pop is issued with fifo_count<2, so the tracker never underflows from this block.

Optional Feature:
- Macro: SCHED_STATS_EN.
- When defined, the block adds:
  - output issue_cnt (32 bits): increments on every fifo_pop; wraps at 2^32.
  - output stall_cnt (16 bits): increments on each ISSUE cycle blocked by fifo_wr; saturates at 16'hFFFF.
  - Both counters are reset to 0 by rst_n.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Basic issue:
  - Stimulus: reset; sched_en=1; fifo_count=2; win_addr0=20'h00010, win_addr1=20'h00011; fifo_wr=0.
  - Response: fifo_pop and dec_start=8'b0000_0011 pulse for one cycle, 2 cycles after eligibility; dec_addr_even=20'h00010, dec_addr_odd=20'h00011; dec_busy=8'h03.
- Round-robin:
  - Stimulus: fifo_count=8 held; no dec_done.
  - Response: starts go to pairs 0,1,2,3 (dec_start 03,0C,30,C0), 3 cycles apart; then no further issue; dec_busy=8'hFF.
- Release and regrant:
  - Stimulus: after the round-robin test, pulse dec_done[5] only, then later dec_done[4].
  - Response: no issue after done[5] alone; after done[4], the next start is 8'h30 with rr_ptr wrapping correctly.
- Write collision:
  - Stimulus: in ISSUE, hold fifo_wr=1 for 3 cycles.
  - Response: no pop or start during those 3 cycles; issue on the first cycle fifo_wr=0; stall_cnt=3 if SCHED_STATS_EN.
- Boundary:
  - Stimulus: fifo_count=1 with sched_en=1.
  - Response: no pop ever.
- Spurious done:
  - Stimulus: dec_done[7] while dec_busy=0.
  - Response: done_err=1 and sticky.
- Async reset:
  - Stimulus: assert rst_n=0 mid-ISSUE.
  - Response: all outputs immediately return to reset values.

Source files
------------

// File: rtl/decoder_dispatch_scheduler.sv
`timescale 1ns/1ps
// decoder_dispatch_scheduler
//
// Pops the address tracker two entries at a time and hands the head window
// (head+0, head+1) to an idle decoder pair, chosen round-robin. Per-decoder
// busy flags come from start/done pulses, so the tracker is only popped when
// a pair can take the work.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sched_en       dispatch enable (low blocks new grants only)
//   fifo_count     tracker occupancy
//   fifo_wr        tracker write strobe this cycle
//   win_addr0/1    tracker head+0 / head+1 addresses
//   dec_done       per-decoder completion pulses
//   fifo_pop       pop-two strobe to the tracker
//   dec_start      per-decoder start pulses
//   dec_addr_even  address for the even decoder of the granted pair
//   dec_addr_odd   address for the odd decoder of the granted pair
//   dec_busy       registered per-decoder busy flags
//   sched_idle     FSM idle and no decoder busy
//   done_err       sticky: done seen for a non-busy decoder
//
// Optional: define SCHED_STATS_EN to add issue_cnt (32-bit, wraps) and
// stall_cnt (16-bit, saturating) counters.
module decoder_dispatch_scheduler #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned NUM_PAIRS = 4,
  parameter int unsigned CNT_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sched_en,
  input  logic [CNT_W-1:0]       fifo_count,
  input  logic                   fifo_wr,
  input  logic [ADDR_W-1:0]      win_addr0,
  input  logic [ADDR_W-1:0]      win_addr1,
  input  logic [2*NUM_PAIRS-1:0] dec_done,
  output logic                   fifo_pop,
  output logic [2*NUM_PAIRS-1:0] dec_start,
  output logic [ADDR_W-1:0]      dec_addr_even,
  output logic [ADDR_W-1:0]      dec_addr_odd,
  output logic [2*NUM_PAIRS-1:0] dec_busy,
  output logic                   sched_idle,
  output logic                   done_err
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]            issue_cnt,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int unsigned NumDec = 2 * NUM_PAIRS;
  localparam int unsigned PtrW   = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StSettle} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     grant_q, grant_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NumDec-1:0]   busy_q, busy_d;
  logic [NumDec-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   addr_even_q, addr_even_d;
  logic [ADDR_W-1:0]   addr_odd_q, addr_odd_d;
  logic                pop_q, pop_d;
  logic                idle_q, idle_d;
  logic                err_q, err_d;

  logic [NUM_PAIRS-1:0] pair_idle;
  logic [PtrW-1:0]      rr_pick;
  logic                 pick_found;
  logic                 eligible;
  logic                 issue;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
      pair_idle[p] = ~busy_q[2*p] & ~busy_q[2*p+1];
    end
  end

  // First idle pair at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    rr_pick    = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_PAIRS; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_PAIRS;
      if (!pick_found && pair_idle[PtrW'(idx)]) begin
        pick_found = 1'b1;
        rr_pick    = PtrW'(idx);
      end
    end
  end

  assign eligible = sched_en && (fifo_count >= CNT_W'(2)) && pick_found;
  // A pop coinciding with a tracker write is lost, so issue waits it out.
  assign issue    = (state_q == StIssue) && !fifo_wr;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (eligible) begin
          state_d = StIssue;
          grant_d = rr_pick;
        end
      end
      StIssue:  if (!fifo_wr) state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs and busy tracking (next values of the output registers)
  always_comb begin
    pop_d       = issue;
    start_d     = '0;
    addr_even_d = addr_even_q;
    addr_odd_d  = addr_odd_q;
    rr_ptr_d    = rr_ptr_q;
    if (issue) begin
      start_d[{grant_q, 1'b0} +: 2] = 2'b11;
      addr_even_d = win_addr0;
      addr_odd_d  = win_addr1;
      rr_ptr_d    = (grant_q == PtrW'(NUM_PAIRS - 1)) ? '0 : grant_q + PtrW'(1);
    end
    busy_d = (busy_q & ~dec_done) | start_d;
    err_d  = err_q | (|(dec_done & ~busy_q));
    idle_d = (state_d == StIdle) && (busy_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      busy_q      <= '0;
      start_q     <= '0;
      addr_even_q <= '0;
      addr_odd_q  <= '0;
      pop_q       <= 1'b0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      addr_even_q <= addr_even_d;
      addr_odd_q  <= addr_odd_d;
      pop_q       <= pop_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
    end
  end

  assign fifo_pop      = pop_q;
  assign dec_start     = start_q;
  assign dec_addr_even = addr_even_q;
  assign dec_addr_odd  = addr_odd_q;
  assign dec_busy      = busy_q;
  assign sched_idle    = idle_q;
  assign done_err      = err_q;

`ifdef SCHED_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue) issue_cnt_q <= issue_cnt_q + 32'd1;
      if ((state_q == StIssue) && fifo_wr && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_dispatch_scheduler.sv
`timescale 1ns/1ps
// Bench for decoder_dispatch_scheduler: directed phases plus random traffic,
// scored against a transaction-level model of the dispatch rules.
module tb_decoder_dispatch_scheduler;

  localparam int AW = 20;
  localparam int NP = 4;
  localparam int CW = 10;
  localparam int ND = 2 * NP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sched_en = 1'b0;
  logic [CW-1:0] fifo_count = '0;
  logic          fifo_wr = 1'b0;
  logic [AW-1:0] win_addr0 = '0;
  logic [AW-1:0] win_addr1 = '0;
  logic [ND-1:0] dec_done = '0;
  logic          fifo_pop;
  logic [ND-1:0] dec_start;
  logic [AW-1:0] dec_addr_even;
  logic [AW-1:0] dec_addr_odd;
  logic [ND-1:0] dec_busy;
  logic          sched_idle;
  logic          done_err;
`ifdef SCHED_STATS_EN
  logic [31:0]   issue_cnt;
  logic [15:0]   stall_cnt;
`endif

  decoder_dispatch_scheduler #(
    .ADDR_W    (AW),
    .NUM_PAIRS (NP),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sched_en      (sched_en),
    .fifo_count    (fifo_count),
    .fifo_wr       (fifo_wr),
    .win_addr0     (win_addr0),
    .win_addr1     (win_addr1),
    .dec_done      (dec_done),
    .fifo_pop      (fifo_pop),
    .dec_start     (dec_start),
    .dec_addr_even (dec_addr_even),
    .dec_addr_odd  (dec_addr_odd),
    .dec_busy      (dec_busy),
    .sched_idle    (sched_idle),
    .done_err      (done_err)
`ifdef SCHED_STATS_EN
    ,
    .issue_cnt     (issue_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;
  int pop_seen = 0;

  typedef struct {
    int            cyc;
    logic [ND-1:0] start;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
  } issue_t;

  typedef struct {
    int            cyc;
    logic [ND-1:0] busy;
    logic          err;
    logic          idle;
  } stat_t;

  issue_t iss_q[$];
  stat_t  stat_q[$];

  // Model: busy set per decoder, round-robin pointer, a pending grant
  // (-1 = none) and a one-cycle settle gap after each issue.
  logic [ND-1:0] m_busy;
  int            m_rr;
  int            m_granted;
  bit            m_hold;
  bit            m_err;
  int            m_stall;
  int            m_issues;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_rr = 0; m_granted = -1; m_hold = 1'b0; m_err = 1'b0;
    m_stall = 0; m_issues = 0;
    iss_q.delete();
    stat_q.delete();
  endtask

  // Predicts what the DUT shows after the coming edge, from the inputs now applied.
  task automatic model_step();
    logic [ND-1:0] old_busy;
    logic [ND-1:0] set_v;
    issue_t        it;
    stat_t         st;
    bit            found;
    old_busy = m_busy;
    set_v    = '0;
    if (m_granted >= 0) begin
      if (!fifo_wr) begin
        set_v    = ND'(2'b11) << (2 * m_granted);
        it.cyc   = cyc + 1;
        it.start = set_v;
        it.a0    = win_addr0;
        it.a1    = win_addr1;
        iss_q.push_back(it);
        m_rr      = (m_granted + 1) % NP;
        m_granted = -1;
        m_hold    = 1'b1;
        m_issues++;
      end else if (m_stall < 65535) begin
        m_stall++;
      end
    end else if (m_hold) begin
      m_hold = 1'b0;
    end else if (sched_en && fifo_count >= 2) begin
      found = 1'b0;
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_rr + k) % NP;
        if (!found && old_busy[2*p +: 2] == 2'b00) begin
          found     = 1'b1;
          m_granted = p;
        end
      end
    end
    for (int i = 0; i < ND; i++) begin
      if (dec_done[i]) begin
        if (old_busy[i]) m_busy[i] = 1'b0;
        else m_err = 1'b1;
      end
    end
    m_busy  = m_busy | set_v;
    st.cyc  = cyc + 1;
    st.busy = m_busy;
    st.err  = m_err;
    st.idle = (m_granted < 0) && !m_hold && (m_busy == '0);
    stat_q.push_back(st);
  endtask

  task automatic drive(input bit en, input int cnt, input bit wr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [ND-1:0] done);
    @(posedge clk);
    #1;
    sched_en   = en;
    fifo_count = CW'(cnt);
    fifo_wr    = wr;
    win_addr0  = a0;
    win_addr1  = a1;
    dec_done   = done;
    model_step();
  endtask

  function automatic logic [ND-1:0] rand_done(input logic [ND-1:0] busy);
    logic [ND-1:0] m;
    for (int i = 0; i < ND; i++) m[i] = busy[i] && ($urandom_range(7) == 0);
    return m;
  endfunction

  function automatic logic [AW-1:0] ra();
    return AW'($urandom);
  endfunction

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(3) != 0, int'($urandom_range(9)), $urandom_range(3) == 0,
            ra(), ra(), rand_done(m_busy));
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, '0, '0, '0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pop"}, 32'(fifo_pop), 0);
    check({tag, "_start"}, 32'(dec_start), 0);
    check({tag, "_busy"}, 32'(dec_busy), 0);
    check({tag, "_err"}, 32'(done_err), 0);
    check({tag, "_idle"}, 32'(sched_idle), 1);
    check({tag, "_addr_even"}, 32'(dec_addr_even), 0);
    check({tag, "_addr_odd"}, 32'(dec_addr_odd), 0);
`ifdef SCHED_STATS_EN
    check({tag, "_issue_cnt"}, issue_cnt, 0);
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
`endif
  endtask

  // Monitor: per-cycle status and every start/pop pulse against the queues.
  initial begin
    issue_t e;
    stat_t  s;
    forever begin
      @(negedge clk);
      if (checking) begin
        if (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
          s = stat_q.pop_front();
          checks++;
          if ({dec_busy, done_err, sched_idle} !== {s.busy, s.err, s.idle}) begin
            errors++;
            $display("FAIL status cyc %0d: busy %h err %b idle %b, required busy %h err %b idle %b",
                     cyc, dec_busy, done_err, sched_idle, s.busy, s.err, s.idle);
          end
        end
        while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
          e = iss_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_issue cyc %0d: no pulse, required start %h", e.cyc, e.start);
        end
        if (fifo_pop || dec_start != '0) begin
          pop_seen++;
          checks++;
          if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
            e = iss_q.pop_front();
            if ({fifo_pop, dec_start, dec_addr_even, dec_addr_odd} !== {1'b1, e.start, e.a0, e.a1}) begin
              errors++;
              $display("FAIL issue cyc %0d: pop %b start %h even %h odd %h, required pop 1 start %h even %h odd %h",
                       cyc, fifo_pop, dec_start, dec_addr_even, dec_addr_odd, e.start, e.a0, e.a1);
            end
          end else begin
            errors++;
            $display("FAIL unexpected_issue cyc %0d: pop %b start %h, required no pulse",
                     cyc, fifo_pop, dec_start);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    model_reset();
    checking = 1'b1;

    // Boundary: a single queued entry is never dispatched.
    pop_seen = 0;
    for (int i = 0; i < 20; i++) drive(1'b1, (i < 15) ? 1 : 0, 1'b0, ra(), ra(), '0);
    check("boundary_no_pop", 32'(pop_seen), 0);

    // Spurious done on an idle decoder sets the sticky error.
    drive(1'b0, 0, 1'b0, '0, '0, 8'h80);
    quiet(3);
    check("done_err_sticky", 32'(done_err), 1);

    // Basic issue to pair 0, then round-robin across all pairs.
    for (int i = 0; i < 3; i++) drive(1'b1, 2, 1'b0, 20'h00010, 20'h00011, '0);
    for (int i = 0; i < 15; i++) drive(1'b1, 8, 1'b0, ra(), ra(), '0);
    check("rr_all_busy", 32'(dec_busy), 32'hFF);

    // Release: done[5] alone frees nothing; done[4] then frees pair 2.
    drive(1'b1, 8, 1'b0, ra(), ra(), 8'h20);
    for (int i = 0; i < 6; i++) drive(1'b1, 8, 1'b0, ra(), ra(), '0);
    drive(1'b1, 8, 1'b0, ra(), ra(), 8'h10);
    for (int i = 0; i < 6; i++) drive(1'b1, 8, 1'b0, ra(), ra(), '0);
    check("regrant_busy", 32'(dec_busy), 32'hFF);

    // Write collision: three ISSUE cycles blocked by fifo_wr.
    drive(1'b1, 8, 1'b1, ra(), ra(), 8'h03);
    for (int i = 0; i < 4; i++) drive(1'b1, 8, 1'b1, ra(), ra(), '0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8, 1'b0, ra(), ra(), '0);
    quiet(4);
`ifdef SCHED_STATS_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("issue_cnt", issue_cnt, 32'(m_issues));
`endif

    random_run(400);

    // Async reset while a grant sits in ISSUE.
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b0, '0, '0, m_busy);
    for (int n = 0; n < 50 && m_granted < 0; n++) drive(1'b1, 4, 1'b1, ra(), ra(), '0);
    @(posedge clk);
    #2;
    checking = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    sched_en = 1'b0; fifo_count = '0; fifo_wr = 1'b0; dec_done = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    checking = 1'b1;

    random_run(80);
    quiet(6);
`ifdef SCHED_STATS_EN
    check("issue_cnt_end", issue_cnt, 32'(m_issues));
    check("stall_cnt_end", 32'(stall_cnt), 32'(m_stall));
`endif
    @(negedge clk);
    check("issue_queue_drained", 32'(iss_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
